// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and helpers for the multicycle multiply/divide unit.
// Holds the op select encoding, FSM state encoding and a negation helper.
// Sized generously so any operand width up to 63 bits can reuse the helper.

package mult_div_unit_pkg;

  // Operation select sampled with start
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Width of the negation helper; callers zero-extend into it and slice back
  localparam int MAX_DW = 128;

  // Two's-complement negation
  function automatic logic [MAX_DW-1:0] twos_neg(input logic [MAX_DW-1:0] x);
    return ~x + {{(MAX_DW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) unit.
// Latency: WIDTH+1 edges after acceptance (1 edge for divide-by-zero).
// No backpressure: start is only sampled while idle, otherwise dropped.

import mult_div_unit_pkg::*;

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic             op_q;       // latched operation
  logic             neg_res;    // sign(A) xor sign(B): negate product / quotient
  logic             neg_rem;    // sign(A): negate remainder
  logic             dz_pend;    // FIX entered straight from IDLE on divide by zero
  logic [CW-1:0]    cnt;        // iteration counter 0..WIDTH-1
  logic [DW-1:0]    acc;        // shared shift register: product, or {rem, quot}
  logic [WIDTH-1:0] mag;        // |multiplicand| or |divisor|

  logic             accept;
  logic             div_by_zero;

  assign accept      = (state == ST_IDLE) && start;
  assign div_by_zero = (op == OP_DIV) && (B == '0);

  // Input magnitudes; |-2^(W-1)| = 2^(W-1) still fits the unsigned W bits
  logic [MAX_DW-1:0] a_neg_w, b_neg_w;
  logic [WIDTH-1:0]  a_mag, b_mag;

  assign a_neg_w = twos_neg(MAX_DW'(A));
  assign b_neg_w = twos_neg(MAX_DW'(B));
  assign a_mag   = A[WIDTH-1] ? a_neg_w[WIDTH-1:0] : A;
  assign b_mag   = B[WIDTH-1] ? b_neg_w[WIDTH-1:0] : B;

  // Multiply step: conditionally add multiplicand into the upper half, shift right
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_next;

  assign mul_sum  = {1'b0, acc[DW-1:WIDTH]} + {1'b0, mag};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[DW-1:1]};

  // Divide step: shift {rem, quot} left, trial-subtract the divisor.
  // The remainder stays below |B| <= 2^(W-1), so the bit shifted out is always 0.
  logic [DW-1:0]    div_sh;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [DW-1:0]    div_next;

  assign div_sh   = {acc[DW-2:0], 1'b0};
  assign rem_sh   = div_sh[DW-1:WIDTH];
  assign rem_ge   = (rem_sh >= mag);
  assign rem_sub  = rem_sh - mag;
  assign div_next = rem_ge ? {rem_sub, div_sh[WIDTH-1:1], 1'b1} : div_sh;

  // Sign correction applied in FIX
  logic [MAX_DW-1:0] prod_neg_w, quot_neg_w, rem_neg_w;
  logic [DW-1:0]     prod_fix;
  logic [WIDTH-1:0]  quot_fix, rem_fix;

  assign prod_neg_w = twos_neg(MAX_DW'(acc));
  assign quot_neg_w = twos_neg(MAX_DW'(acc[WIDTH-1:0]));
  assign rem_neg_w  = twos_neg(MAX_DW'(acc[DW-1:WIDTH]));
  assign prod_fix   = neg_res ? prod_neg_w[DW-1:0]   : acc;
  assign quot_fix   = neg_res ? quot_neg_w[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix    = neg_rem ? rem_neg_w[WIDTH-1:0]  : acc[DW-1:WIDTH];

  // Upper bits of the wide negation results carry no information
  logic unused_neg_bits;
  assign unused_neg_bits = ^{a_neg_w[MAX_DW-1:WIDTH], b_neg_w[MAX_DW-1:WIDTH],
                             prod_neg_w[MAX_DW-1:DW], quot_neg_w[MAX_DW-1:WIDTH],
                             rem_neg_w[MAX_DW-1:WIDTH]};

  // Controller: sequencing, operand-sign capture and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULT;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_pend  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            neg_res  <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem  <= A[WIDTH-1];
            cnt      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            dz_pend  <= div_by_zero;
            state    <= div_by_zero ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (dz_pend) begin
            // Divide by zero leaves the previous result untouched
            div_zero <= 1'b1;
          end else if (op_q == OP_MULT) begin
            HI <= prod_fix[DW-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end else begin
            HI <= rem_fix;
            LO <= quot_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: load magnitudes on acceptance, iterate one bit per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      mag <= '0;
    end else if (accept) begin
      if (op == OP_MULT) begin
        acc <= {{WIDTH{1'b0}}, b_mag};
        mag <= a_mag;
      end else begin
        acc <= {{WIDTH{1'b0}}, a_mag};
        mag <= b_mag;
      end
    end else if (state == ST_RUN) begin
      acc <= (op_q == OP_MULT) ? mul_next : div_next;
    end
  end

endmodule
